// File: rtl/sargantana_icache_pkg.sv
// Shared icache line-fill types and geometry.
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_PADDR_W = 40;
  localparam int unsigned ICACHE_LINE_W  = 512;
  localparam int unsigned ICACHE_BEAT_W  = 128;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } ifill_state_t;

  // Beat counter width; a single-beat line still needs one bit.
  function automatic int unsigned beat_cnt_w(input int unsigned n_beats);
    if (n_beats > 1) return $clog2(n_beats);
    return 1;
  endfunction

endpackage

// File: rtl/sargantana_icache_line_asm.sv
// Cache line register written one beat slot at a time.
module sargantana_icache_line_asm
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned LINE_W = ICACHE_LINE_W,
  parameter int unsigned BEAT_W = ICACHE_BEAT_W,
  parameter int unsigned IDX_W  = beat_cnt_w(LINE_W / BEAT_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  beat_idx_i,
  input  logic [BEAT_W-1:0] beat_data_i,
  output logic [LINE_W-1:0] line_o
);

  localparam int unsigned N_BEATS = LINE_W / BEAT_W;

  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      line_q <= '0;
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < N_BEATS; i++) begin
        if (beat_idx_i == IDX_W'(i)) line_q[i*BEAT_W +: BEAT_W] <= beat_data_i;
      end
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/sargantana_icache_ifill.sv
// Icache line-fill engine: one line request to L2, beat assembly, kill draining.
module sargantana_icache_ifill
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned PADDR_W = ICACHE_PADDR_W,
  parameter int unsigned LINE_W  = ICACHE_LINE_W,
  parameter int unsigned BEAT_W  = ICACHE_BEAT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ifill_req_valid_i,
  input  logic [PADDR_W-1:0] ifill_paddr_i,
  input  logic               kill_i,
  output logic               ifill_sent_ack_o,
  output logic               ifill_resp_valid_o,
  output logic               valid_ifill_resp_o,
  output logic [LINE_W-1:0]  ifill_line_o,
  output logic               ifill_err_o,
  output logic               l2_req_valid_o,
  input  logic               l2_req_ready_i,
  output logic [PADDR_W-1:0] l2_req_addr_o,
  input  logic               l2_resp_valid_i,
  input  logic [BEAT_W-1:0]  l2_resp_data_i,
  input  logic               l2_resp_last_i,
  input  logic               l2_resp_err_i
);

  localparam int unsigned N_BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W   = beat_cnt_w(N_BEATS);
  localparam int unsigned OFF_W   = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(N_BEATS - 1);
  localparam logic [PADDR_W-1:0] OFF_MASK = PADDR_W'((64'd1 << OFF_W) - 64'd1);

  ifill_state_t       state_q;
  logic [PADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               kill_q;
  logic               req_valid_q;
  logic               ack_q;

  logic start, beat_wr, last_beat, is_done;
  logic [CNT_W-1:0] cnt_inc;

  assign start     = (state_q == IDLE) && ifill_req_valid_i && !kill_i;
  assign beat_wr   = (state_q == WAIT) && l2_resp_valid_i;
  assign last_beat = l2_resp_valid_i && l2_resp_last_i;
  assign is_done   = (state_q == DONE);
  assign cnt_inc   = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q      <= ifill_paddr_i & ~OFF_MASK;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b1;
            ack_q       <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // Kill is remembered but never retracts an offered request.
          if (l2_req_ready_i) begin
            req_valid_q <= 1'b0;
            kill_q      <= 1'b0;
            state_q     <= (kill_i || kill_q) ? DRAIN : WAIT;
          end else begin
            kill_q <= kill_q | kill_i;
          end
        end
        WAIT: begin
          if (l2_resp_valid_i) begin
            cnt_q <= cnt_inc;
            err_q <= err_q | l2_resp_err_i | (l2_resp_last_i && (cnt_q != LAST_IDX));
          end
          if (kill_i) begin
            state_q <= last_beat ? IDLE : DRAIN;
            ack_q   <= !last_beat;
          end else if (last_beat) begin
            state_q <= DONE;
            ack_q   <= 1'b0;
          end
        end
        DRAIN: begin
          if (last_beat) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        DONE: begin
          cnt_q   <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
          ack_q       <= 1'b0;
        end
      endcase
    end
  end

  sargantana_icache_line_asm #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (CNT_W)
  ) u_line_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (start),
    .wr_en_i     (beat_wr),
    .beat_idx_i  (cnt_q),
    .beat_data_i (l2_resp_data_i),
    .line_o      (ifill_line_o)
  );

  // A kill in the delivery cycle suppresses the write strobe.
  assign ifill_resp_valid_o = is_done && !kill_i;
  assign valid_ifill_resp_o = is_done && !kill_i && !err_q;
  assign ifill_err_o        = is_done && err_q;
  assign ifill_sent_ack_o   = ack_q;
  assign l2_req_valid_o     = req_valid_q;
  assign l2_req_addr_o      = addr_q;

endmodule

// File: tb/tb_sargantana_icache_ifill.sv
// Self-checking bench for the icache line-fill engine: directed table, corner sequences, random fills.
module tb_sargantana_icache_ifill;

  localparam int unsigned PADDR_W = 40;
  localparam int unsigned LINE_W  = 512;
  localparam int unsigned BEAT_W  = 128;
  localparam int unsigned NB      = LINE_W / BEAT_W;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               ifill_req_valid_i;
  logic [PADDR_W-1:0] ifill_paddr_i;
  logic               kill_i;
  logic               ifill_sent_ack_o;
  logic               ifill_resp_valid_o;
  logic               valid_ifill_resp_o;
  logic [LINE_W-1:0]  ifill_line_o;
  logic               ifill_err_o;
  logic               l2_req_valid_o;
  logic               l2_req_ready_i;
  logic [PADDR_W-1:0] l2_req_addr_o;
  logic               l2_resp_valid_i;
  logic [BEAT_W-1:0]  l2_resp_data_i;
  logic               l2_resp_last_i;
  logic               l2_resp_err_i;

  sargantana_icache_ifill dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .ifill_req_valid_i  (ifill_req_valid_i),
    .ifill_paddr_i      (ifill_paddr_i),
    .kill_i             (kill_i),
    .ifill_sent_ack_o   (ifill_sent_ack_o),
    .ifill_resp_valid_o (ifill_resp_valid_o),
    .valid_ifill_resp_o (valid_ifill_resp_o),
    .ifill_line_o       (ifill_line_o),
    .ifill_err_o        (ifill_err_o),
    .l2_req_valid_o     (l2_req_valid_o),
    .l2_req_ready_i     (l2_req_ready_i),
    .l2_req_addr_o      (l2_req_addr_o),
    .l2_resp_valid_i    (l2_resp_valid_i),
    .l2_resp_data_i     (l2_resp_data_i),
    .l2_resp_last_i     (l2_resp_last_i),
    .l2_resp_err_i      (l2_resp_err_i)
  );

  always #5 clk = ~clk;

  // kill_ph: 0 none, 1 during REQ (at ready-wait cycle kill_at), 2 on WAIT beat kill_at, 3 in DONE
  typedef struct {
    logic [PADDR_W-1:0] paddr;
    int                 rdy_dly;
    int                 nb;
    int                 gap;
    int                 err_beat;
    int                 kill_ph;
    int                 kill_at;
    bit                 exp_del;
    bit                 exp_vld;
    bit                 exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifill_req_valid_i = 1'b0;
    kill_i            = 1'b0;
    l2_req_ready_i    = 1'b0;
    l2_resp_valid_i   = 1'b0;
    l2_resp_data_i    = '0;
    l2_resp_last_i    = 1'b0;
    l2_resp_err_i     = 1'b0;
  endtask

  // Reference model: the outcome follows from whether any kill happened and whether the line is well formed.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit bad = (v.err_beat >= 0 && v.err_beat < v.nb) || ((v.nb % NB) != 0);
    r.exp_del = (v.kill_ph == 0);
    r.exp_vld = r.exp_del && !bad;
    r.exp_err = bad;
    return r;
  endfunction

  task automatic run_fill(input vec_t v, input bit rnd);
    logic [BEAT_W-1:0]  beats [8];
    logic [LINE_W-1:0]  exp_line;
    logic [PADDR_W-1:0] exp_addr;
    int hs;
    for (int b = 0; b < v.nb; b++)
      beats[b] = rnd ? {$urandom(), $urandom(), $urandom(), $urandom()} : {32{4'(10 + b)}};
    exp_addr = v.paddr - (v.paddr % 64);
    exp_line = '0;
    for (int b = 0; b < v.nb; b++) exp_line[(b % NB)*BEAT_W +: BEAT_W] = beats[b];

    ifill_req_valid_i = 1'b1;
    ifill_paddr_i     = v.paddr;
    kill_i            = 1'b0;
    step();
    ifill_req_valid_i = 1'b0;
    ifill_paddr_i     = ~v.paddr;
    hs = 0;
    for (int d = 0; d <= v.rdy_dly; d++) begin
      l2_req_ready_i = (d == v.rdy_dly);
      kill_i         = (v.kill_ph == 1) && (d == v.kill_at);
      #1;
      chk1("req_valid", l2_req_valid_o, 1'b1);
      chkw("req_addr", LINE_W'(l2_req_addr_o), LINE_W'(exp_addr));
      chk1("ack_req", ifill_sent_ack_o, 1'b1);
      if (l2_req_valid_o && l2_req_ready_i) hs++;
      step();
    end
    l2_req_ready_i = 1'b0;
    kill_i         = 1'b0;
    chkw("handshakes", LINE_W'(hs), LINE_W'(1));

    for (int b = 0; b < v.nb; b++) begin
      for (int g = 0; g < v.gap; g++) begin
        l2_resp_valid_i = 1'b0;
        kill_i          = 1'b0;
        #1;
        chk1("ack_gap", ifill_sent_ack_o, 1'b1);
        step();
      end
      l2_resp_valid_i = 1'b1;
      l2_resp_data_i  = beats[b];
      l2_resp_last_i  = (b == v.nb - 1);
      l2_resp_err_i   = (b == v.err_beat);
      kill_i          = (v.kill_ph == 2) && (b == v.kill_at);
      #1;
      chk1("ack_beat", ifill_sent_ack_o, 1'b1);
      chk1("req_idle", l2_req_valid_o, 1'b0);
      chk1("no_early_resp", ifill_resp_valid_o, 1'b0);
      step();
    end

    idle_inputs();
    kill_i = (v.kill_ph == 3);
    #1;
    chk1("resp_valid", ifill_resp_valid_o, v.exp_del);
    chk1("valid_resp", valid_ifill_resp_o, v.exp_vld);
    chk1("ack_done", ifill_sent_ack_o, 1'b0);
    if (v.exp_del) begin
      chkw("line", ifill_line_o, exp_line);
      chk1("err", ifill_err_o, v.exp_err);
    end
    step();
    kill_i = 1'b0;
    #1;
    chk1("resp_pulse_end", ifill_resp_valid_o, 1'b0);
    chk1("ack_idle", ifill_sent_ack_o, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_ack"}, ifill_sent_ack_o, 1'b0);
    chk1({tag, "_resp"}, ifill_resp_valid_o, 1'b0);
    chk1({tag, "_vresp"}, valid_ifill_resp_o, 1'b0);
    chk1({tag, "_err"}, ifill_err_o, 1'b0);
    chk1({tag, "_reqv"}, l2_req_valid_o, 1'b0);
    chkw({tag, "_addr"}, LINE_W'(l2_req_addr_o), '0);
    chkw({tag, "_line"}, ifill_line_o, '0);
  endtask

  vec_t tbl [11];

  initial begin
    vec_t rv;
    tbl[0]  = '{40'h0080001234, 0, 4, 0, -1, 0, 0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{40'h0080001234, 5, 4, 0, -1, 0, 0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{40'h0012345678, 0, 4, 0, -1, 2, 1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{40'h00DEADBEEF, 3, 4, 1, -1, 1, 1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{40'h0000000040, 1, 4, 0,  1, 0, 0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{40'h0000000FC0, 0, 4, 0, -1, 3, 0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{40'hFFFFFFFFFF, 2, 4, 2, -1, 0, 0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{40'h000000003F, 0, 3, 0, -1, 0, 0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{40'h5555555555, 0, 5, 1, -1, 0, 0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{40'h0011223344, 0, 4, 0, -1, 2, 3, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{40'h00A5A5A5A5, 2, 4, 0, -1, 1, 2, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    ifill_paddr_i = '0;
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    #1;
    chk_all_zero("reset");

    // Request coinciding with kill in IDLE is ignored.
    ifill_req_valid_i = 1'b1;
    ifill_paddr_i     = 40'h0000001000;
    kill_i            = 1'b1;
    step();
    idle_inputs();
    #1;
    chk1("killed_req_valid", l2_req_valid_o, 1'b0);
    chk1("killed_req_ack", ifill_sent_ack_o, 1'b0);

    // Stray last beat in IDLE is dropped.
    l2_resp_valid_i = 1'b1;
    l2_resp_last_i  = 1'b1;
    l2_resp_data_i  = '1;
    step();
    idle_inputs();
    #1;
    chk1("stray_beat_resp", ifill_resp_valid_o, 1'b0);
    chk1("stray_beat_ack", ifill_sent_ack_o, 1'b0);

    for (int i = 0; i < 11; i++) run_fill(tbl[i], 1'b0);

    // Reset in the middle of WAIT abandons the fill.
    ifill_req_valid_i = 1'b1;
    ifill_paddr_i     = 40'h0000ABCD00;
    step();
    ifill_req_valid_i = 1'b0;
    l2_req_ready_i    = 1'b1;
    step();
    l2_req_ready_i  = 1'b0;
    l2_resp_valid_i = 1'b1;
    l2_resp_data_i  = {4{32'h1234_5678}};
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    idle_inputs();
    #1;
    chk_all_zero("midfill_reset");
    run_fill(tbl[0], 1'b1);

    for (int i = 0; i < 40; i++) begin
      rv.paddr    = {8'($urandom()), 32'($urandom())};
      rv.rdy_dly  = int'($urandom_range(0, 4));
      rv.nb       = int'($urandom_range(1, 6));
      rv.gap      = int'($urandom_range(0, 2));
      rv.err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      rv.kill_ph  = int'($urandom_range(0, 6));
      if (rv.kill_ph > 3) rv.kill_ph = 0;
      rv.kill_at  = (rv.kill_ph == 1) ? int'($urandom_range(0, 32'(rv.rdy_dly))) :
                    (rv.kill_ph == 2) ? int'($urandom_range(0, 32'(rv.nb - 1))) : 0;
      run_fill(model(rv), 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
